elevator_car_ctrl: RTL and testbench

ELEVATOR_CAR_CTRL -- requirements
Module: elevator_car_ctrl

---
 rtl/elevator_pkg.sv | 18 +
 rtl/elevator_car_timer.sv | 26 ++
 rtl/elevator_car_ctrl.sv | 115 +++++++++++
 tb/tb_elevator_car_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared state type and sizing helpers for the elevator car controller
package elevator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVE_UP,
        ST_MOVE_DOWN,
        ST_DOOR_OPEN
    } car_state_t;

    localparam int DEFAULT_NUM_FLOORS = 4;

    // Width needed to encode values 0..n-1, never less than one bit.
    function automatic int floor_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/elevator_car_timer.sv
// rtl/elevator_car_timer.sv - loadable down-counter timing both travel and door dwell
module car_timer #(
    parameter int WIDTH = 3
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/elevator_car_ctrl.sv
// rtl/elevator_car_ctrl.sv - single-car elevator controller with directional request scheduling
module elevator_car_ctrl
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = DEFAULT_NUM_FLOORS,
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 4,
    localparam int FLOOR_W      = floor_w(NUM_FLOORS)
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [NUM_FLOORS-1:0] req,
    output logic [NUM_FLOORS-1:0] done,
    output logic [FLOOR_W-1:0]    cur_floor,
    output logic                  moving_up,
    output logic                  moving_down,
    output logic                  door_open
);

    localparam int TIMER_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TIMER_W   = floor_w(TIMER_MAX);

    car_state_t            state, state_next;
    logic                  dir_up, dir_next;
    logic [FLOOR_W-1:0]    floor_next;
    logic [NUM_FLOORS-1:0] done_next;
    logic                  any_above, any_below, here_req;
    logic                  timer_load, timer_expired;
    logic [TIMER_W-1:0]    timer_value;

    always_comb begin
        any_above = 1'b0;
        any_below = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(cur_floor)) any_above = any_above | req[i];
            if (i < int'(cur_floor)) any_below = any_below | req[i];
        end
        here_req = req[cur_floor];
    end

    // Timer is loaded with N-1 on entry so the state lasts exactly N cycles.
    always_comb begin
        state_next  = state;
        dir_next    = dir_up;
        floor_next  = cur_floor;
        done_next   = '0;
        timer_load  = 1'b0;
        timer_value = '0;
        case (state)
            ST_IDLE: begin
                if (here_req) begin
                    state_next             = ST_DOOR_OPEN;
                    done_next[cur_floor]   = 1'b1;
                    timer_load             = 1'b1;
                    timer_value            = TIMER_W'(DOOR_CYCLES - 1);
                end else if ((dir_up && any_above) || (!dir_up && !any_below && any_above)) begin
                    state_next  = ST_MOVE_UP;
                    dir_next    = 1'b1;
                    timer_load  = 1'b1;
                    timer_value = TIMER_W'(TRAVEL_CYCLES - 1);
                end else if (any_below) begin
                    state_next  = ST_MOVE_DOWN;
                    dir_next    = 1'b0;
                    timer_load  = 1'b1;
                    timer_value = TIMER_W'(TRAVEL_CYCLES - 1);
                end
            end
            ST_MOVE_UP: begin
                if (timer_expired) begin
                    state_next = ST_IDLE;
                    floor_next = cur_floor + FLOOR_W'(1);
                end
            end
            ST_MOVE_DOWN: begin
                if (timer_expired) begin
                    state_next = ST_IDLE;
                    floor_next = cur_floor - FLOOR_W'(1);
                end
            end
            ST_DOOR_OPEN: begin
                if (timer_expired) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= ST_IDLE;
            cur_floor <= '0;
            dir_up    <= 1'b1;
            done      <= '0;
        end else begin
            state     <= state_next;
            cur_floor <= floor_next;
            dir_up    <= dir_next;
            done      <= done_next;
        end
    end

    car_timer #(
        .WIDTH(TIMER_W)
    ) u_timer (
        .Clock     (Clock),
        .Reset     (Reset),
        .load      (timer_load),
        .load_value(timer_value),
        .expired   (timer_expired)
    );

    assign moving_up   = (state == ST_MOVE_UP);
    assign moving_down = (state == ST_MOVE_DOWN);
    assign door_open   = (state == ST_DOOR_OPEN);

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// tb/tb_elevator_car_ctrl.sv - scoreboard bench for elevator_car_ctrl with directed request sequences
module tb_elevator_car_ctrl;

    localparam int M_IDLE = 0;
    localparam int M_UP   = 1;
    localparam int M_DOWN = 2;
    localparam int M_DOOR = 3;

    typedef struct {
        int         floor_num;
        int         mode;
        logic [3:0] done_bits;
    } exp_t;

    logic       Clock;
    logic       Reset;
    logic [3:0] req;
    logic [3:0] done;
    logic [1:0] cur_floor;
    logic       moving_up, moving_down, door_open;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks   = 0;
    int    failures = 0;

    elevator_car_ctrl #(
        .NUM_FLOORS   (4),
        .TRAVEL_CYCLES(4),
        .DOOR_CYCLES  (3)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .req        (req),
        .done       (done),
        .cur_floor  (cur_floor),
        .moving_up  (moving_up),
        .moving_down(moving_down),
        .door_open  (door_open)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Drive one cycle of inputs and queue what must be visible after the next edge.
    task automatic cyc(input bit rst, input logic [3:0] r, input int fl, input int mode,
                       input logic [3:0] dn, input string tag);
        exp_t e;
        @(negedge Clock);
        Reset = rst;
        req   = r;
        e.floor_num = fl;
        e.mode      = mode;
        e.done_bits = dn;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic hold(input int n, input logic [3:0] r, input int fl, input int mode,
                        input string tag);
        for (int k = 0; k < n; k++) cyc(1'b0, r, fl, mode, 4'b0000, tag);
    endtask

    always @(posedge Clock) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t  e;
            string t;
            logic  eu, ed, eo;
            e  = exp_q.pop_front();
            t  = tag_q.pop_front();
            eu = (e.mode == M_UP);
            ed = (e.mode == M_DOWN);
            eo = (e.mode == M_DOOR);
            checks++;
            if (cur_floor !== 2'(e.floor_num) || moving_up !== eu || moving_down !== ed ||
                door_open !== eo || done !== e.done_bits) begin
                failures++;
                $display("FAIL %s: got floor=%0d up=%b down=%b door=%b done=%b, want floor=%0d up=%b down=%b door=%b done=%b",
                         t, cur_floor, moving_up, moving_down, door_open, done,
                         e.floor_num, eu, ed, eo, e.done_bits);
            end
        end
    end

    initial begin
        Reset = 1'b1;
        req   = 4'b0000;

        cyc(1, 4'b0001, 0, M_IDLE, 4'b0000, "reset_state");
        cyc(0, 4'b0001, 0, M_DOOR, 4'b0001, "a_door_done");
        hold(2, 4'b0000, 0, M_DOOR, "a_dwell");
        hold(1, 4'b0000, 0, M_IDLE, "a_idle");

        hold(4, 4'b0100, 0, M_UP,   "b_up_0_1");
        hold(1, 4'b0100, 1, M_IDLE, "b_at_1");
        hold(4, 4'b0100, 1, M_UP,   "b_up_1_2");
        hold(1, 4'b0100, 2, M_IDLE, "b_at_2");
        cyc(0, 4'b0100, 2, M_DOOR, 4'b0100, "b_done");
        hold(2, 4'b0000, 2, M_DOOR, "b_dwell");
        hold(1, 4'b0000, 2, M_IDLE, "b_idle");

        cyc(1, 4'b0000, 0, M_IDLE, 4'b0000, "e_reset");
        hold(2, 4'b0100, 0, M_UP, "e_up");
        cyc(1, 4'b0100, 0, M_IDLE, 4'b0000, "e_reset_mid_move");
        hold(2, 4'b0000, 0, M_IDLE, "e_after_reset");

        hold(4, 4'b0010, 0, M_UP,   "c_up_0_1");
        hold(1, 4'b0010, 1, M_IDLE, "c_at_1");
        cyc(0, 4'b0010, 1, M_DOOR, 4'b0010, "c_done_1");
        hold(2, 4'b0000, 1, M_DOOR, "c_dwell_1");
        hold(1, 4'b0000, 1, M_IDLE, "c_idle_1");
        hold(4, 4'b1001, 1, M_UP,   "c_up_first");
        hold(1, 4'b1001, 2, M_IDLE, "c_at_2");
        hold(4, 4'b1001, 2, M_UP,   "c_up_2_3");
        hold(1, 4'b1001, 3, M_IDLE, "c_at_3");
        cyc(0, 4'b1001, 3, M_DOOR, 4'b1000, "c_done_3");
        hold(2, 4'b0001, 3, M_DOOR, "c_dwell_3");
        hold(1, 4'b0001, 3, M_IDLE, "c_idle_3");
        hold(4, 4'b0001, 3, M_DOWN, "c_down_3_2");
        hold(1, 4'b0001, 2, M_IDLE, "c_down_at_2");
        hold(4, 4'b0001, 2, M_DOWN, "c_down_2_1");
        hold(1, 4'b0001, 1, M_IDLE, "c_down_at_1");
        hold(4, 4'b0001, 1, M_DOWN, "c_down_1_0");
        hold(1, 4'b0001, 0, M_IDLE, "c_down_at_0");
        cyc(0, 4'b0001, 0, M_DOOR, 4'b0001, "c_done_0");
        hold(2, 4'b0000, 0, M_DOOR, "c_dwell_0");
        hold(1, 4'b0000, 0, M_IDLE, "c_idle_0");

        hold(2, 4'b0010, 0, M_UP,   "d_up_start");
        hold(2, 4'b1010, 0, M_UP,   "d_up_no_abort");
        hold(1, 4'b1010, 1, M_IDLE, "d_at_1");
        cyc(0, 4'b1010, 1, M_DOOR, 4'b0010, "d_done_1");
        hold(2, 4'b1000, 1, M_DOOR, "d_dwell_1");
        hold(1, 4'b1000, 1, M_IDLE, "d_idle_1");
        hold(4, 4'b1000, 1, M_UP,   "d_up_1_2");
        hold(1, 4'b1000, 2, M_IDLE, "d_at_2");
        hold(4, 4'b1000, 2, M_UP,   "d_up_2_3");
        hold(1, 4'b1000, 3, M_IDLE, "d_at_3");
        cyc(0, 4'b1000, 3, M_DOOR, 4'b1000, "d_done_3");
        hold(2, 4'b0000, 3, M_DOOR, "d_dwell_3");
        hold(1, 4'b0000, 3, M_IDLE, "d_idle_3");

        cyc(0, 4'b1000, 3, M_DOOR, 4'b1000, "f_first_done");
        hold(1, 4'b0000, 3, M_DOOR, "f_dwell");
        hold(1, 4'b1000, 3, M_DOOR, "f_repress_ignored");
        hold(1, 4'b1000, 3, M_IDLE, "f_back_idle");
        cyc(0, 4'b1000, 3, M_DOOR, 4'b1000, "f_second_done");
        hold(2, 4'b0000, 3, M_DOOR, "f_dwell2");
        hold(1, 4'b0000, 3, M_IDLE, "f_idle");

        cyc(0, 4'b1000, 3, M_DOOR, 4'b1000, "g_door");
        cyc(1, 4'b0000, 0, M_IDLE, 4'b0000, "g_reset_mid_door");
        hold(2, 4'b0000, 0, M_IDLE, "g_after_reset");

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge Clock);
        #2;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
